// File: rtl/dff_bank_if.sv
// Bus bundle for dff_bank: control/data inputs and register outputs.
// conflict_cnt is present only when DFF_BANK_CONFLICT_CNT_EN is defined.
interface dff_bank_if #(
    parameter int unsigned WIDTH = 8
`ifdef DFF_BANK_CONFLICT_CNT_EN
    ,
    parameter int unsigned CNT_W = 4
`endif
);
    logic [1:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic [WIDTH-1:0] set;
    logic [WIDTH-1:0] clr;
    logic             err_clr;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             err;
`ifdef DFF_BANK_CONFLICT_CNT_EN
    logic [CNT_W-1:0] conflict_cnt;
`endif

    modport master (
        output mode, d, sin, set, clr, err_clr,
        input  q, sout, err
`ifdef DFF_BANK_CONFLICT_CNT_EN
        , input conflict_cnt
`endif
    );

    modport slave (
        input  mode, d, sin, set, clr, err_clr,
        output q, sout, err
`ifdef DFF_BANK_CONFLICT_CNT_EN
        , output conflict_cnt
`endif
    );
endinterface

// File: rtl/dff_bank.sv
// Multi-bit register bank with per-bit set/clear, load/shift modes and sticky conflict flag.
// Optional saturating conflict counter enabled by DFF_BANK_CONFLICT_CNT_EN.
module dff_bank #(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
`ifdef DFF_BANK_CONFLICT_CNT_EN
    ,
    parameter int unsigned          CNT_W     = 4
`endif
) (
    input  logic       clk,
    input  logic       clear,
    dff_bank_if.slave  bus
);
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_SHR  = 2'b11;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt_c;
    logic [WIDTH-1:0] m_c;
    logic [WIDTH-1:0] conflict_v_c;
    logic             conflict_c;
    logic             err_r;
    logic             err_nxt_c;

    // Mode result, then per-bit set/clear override; conflicting bits hold.
    always_comb begin
        m_c = q_r;
        unique case (bus.mode)
            MODE_HOLD: m_c = q_r;
            MODE_LOAD: m_c = bus.d;
            MODE_SHL:  m_c = {q_r[WIDTH-2:0], bus.sin};
            MODE_SHR:  m_c = {bus.sin, q_r[WIDTH-1:1]};
            default:   m_c = q_r;
        endcase
        conflict_v_c = bus.set & bus.clr;
        conflict_c   = |conflict_v_c;
        q_nxt_c      = (m_c & ~(bus.set | bus.clr))
                     | (bus.set & ~bus.clr)
                     | (q_r & conflict_v_c);
        err_nxt_c    = conflict_c | (err_r & ~bus.err_clr);
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            q_r   <= RESET_VAL;
            err_r <= 1'b0;
        end else begin
            q_r   <= q_nxt_c;
            err_r <= err_nxt_c;
        end
    end

    assign bus.q    = q_r;
    assign bus.err  = err_r;
    assign bus.sout = (bus.mode == MODE_SHL) ? q_r[WIDTH-1] : q_r[0];

`ifdef DFF_BANK_CONFLICT_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_c;

    // err_clr restarts the count; a same-edge conflict counts as the first event.
    always_comb begin
        cnt_nxt_c = cnt_r;
        if (bus.err_clr) begin
            cnt_nxt_c = CNT_W'(conflict_c);
        end else if (conflict_c && (cnt_r != CNT_MAX)) begin
            cnt_nxt_c = cnt_r + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_c;
        end
    end

    assign bus.conflict_cnt = cnt_r;
`endif
endmodule

// File: tb/tb_dff_bank.sv
// Self-checking bench for dff_bank: directed plan steps then randomized traffic
// compared against a per-bit behavioural model.
module tb_dff_bank;
    localparam int unsigned W   = 8;
    localparam logic [7:0]  RST = 8'hA5;
    localparam int          CNT_SAT = 3;

    logic clk;
    logic clear;
    int   checks;
    int   failures;

    logic [7:0] mq;
    logic       merr;
    int         mcnt;

`ifdef DFF_BANK_CONFLICT_CNT_EN
    dff_bank_if #(.WIDTH(W), .CNT_W(2)) bus ();
    dff_bank #(.WIDTH(W), .RESET_VAL(RST), .CNT_W(2)) dut (
        .clk(clk), .clear(clear), .bus(bus)
    );
`else
    dff_bank_if #(.WIDTH(W)) bus ();
    dff_bank #(.WIDTH(W), .RESET_VAL(RST)) dut (
        .clk(clk), .clear(clear), .bus(bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic exp_sout;
        exp_sout = (bus.mode == 2'b10) ? mq[7] : mq[0];
        chk({tag, ".q"},    32'(bus.q),    32'(mq));
        chk({tag, ".err"},  32'(bus.err),  32'(merr));
        chk({tag, ".sout"}, 32'(bus.sout), 32'(exp_sout));
`ifdef DFF_BANK_CONFLICT_CNT_EN
        chk({tag, ".cnt"},  32'(bus.conflict_cnt), 32'(mcnt));
`endif
    endtask

    task automatic model_reset();
        mq   = RST;
        merr = 1'b0;
        mcnt = 0;
    endtask

    // Advance model by one edge using the currently driven inputs, then compare.
    task automatic tick(input string tag);
        logic [7:0] m;
        logic [7:0] nq;
        logic       conf;
        int         v;
        if (clear) begin
            nq = RST;
        end else begin
            v = int'(mq);
            case (bus.mode)
                2'b00:   v = int'(mq);
                2'b01:   v = int'(bus.d);
                2'b10:   v = ((v * 2) % 256) + int'(bus.sin);
                default: v = (v / 2) + (bus.sin ? 128 : 0);
            endcase
            m = 8'(v);
            conf = 1'b0;
            for (int b = 0; b < 8; b++) begin
                if (bus.set[b] && bus.clr[b]) begin
                    nq[b] = mq[b];
                    conf  = 1'b1;
                end else if (bus.set[b]) nq[b] = 1'b1;
                else if (bus.clr[b])     nq[b] = 1'b0;
                else                     nq[b] = m[b];
            end
        end
        @(posedge clk);
        #1;
        if (clear) begin
            model_reset();
        end else begin
            mq = nq;
            if (bus.err_clr) begin
                merr = conf;
                mcnt = conf ? 1 : 0;
            end else if (conf) begin
                merr = 1'b1;
                mcnt = (mcnt < CNT_SAT) ? mcnt + 1 : CNT_SAT;
            end
        end
        check_state(tag);
    endtask

    task automatic drive(input logic [1:0] mode, input logic [7:0] d, input logic sin,
                         input logic [7:0] set, input logic [7:0] clr, input logic ec);
        bus.mode    = mode;
        bus.d       = d;
        bus.sin     = sin;
        bus.set     = set;
        bus.clr     = clr;
        bus.err_clr = ec;
    endtask

    initial begin
        int exp_cnt [5];
        checks   = 0;
        failures = 0;
        exp_cnt  = '{1, 2, 3, 3, 3};
        clear    = 1'b1;
        drive(2'b00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
        model_reset();
        #2;
        check_state("reset_init");
        @(posedge clk); #1;
        clear = 1'b0;

        // Produce a conflict so the async reset has err to clear
        drive(2'b01, 8'h3C, 1'b0, 8'h02, 8'h02, 1'b0);
        tick("pre_reset");
        chk("pre_reset.err_set", 32'(bus.err), 32'h1);
        drive(2'b01, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0);
        #3;
        clear = 1'b1;
        #1;
        model_reset();
        check_state("async_reset");
        chk("async_reset.q", 32'(bus.q), 32'hA5);
        #1;
        clear = 1'b0;
        tick("reset_release");
        chk("reset_release.q", 32'(bus.q), 32'hFF);

        // Shift left twice with sin=1, then right once with sin=0
        drive(2'b01, 8'h81, 1'b0, 8'h00, 8'h00, 1'b0);
        tick("shift_load");
        drive(2'b10, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0);
        tick("shl1");
        tick("shl2");
        chk("shl2.q", 32'(bus.q), 32'h07);
        drive(2'b11, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
        tick("shr1");
        chk("shr1.q", 32'(bus.q), 32'h03);
        chk("shr1.sout", 32'(bus.sout), 32'h1);

        // Per-bit override over a parallel load
        drive(2'b01, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
        tick("ovr_zero");
        drive(2'b01, 8'h0F, 1'b0, 8'h80, 8'h01, 1'b0);
        tick("override");
        chk("override.q", 32'(bus.q), 32'h8E);

        // Conflict holds the bit and sets err; err_clr behaviour
        drive(2'b01, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b0);
        tick("cf_load");
        drive(2'b01, 8'h00, 1'b0, 8'h01, 8'h01, 1'b0);
        tick("conflict");
        chk("conflict.q", 32'(bus.q), 32'h01);
        chk("conflict.err", 32'(bus.err), 32'h1);
        drive(2'b00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
        tick("err_clr");
        chk("err_clr.err", 32'(bus.err), 32'h0);
        drive(2'b00, 8'h00, 1'b0, 8'h01, 8'h01, 1'b1);
        tick("err_clr_cf");
        chk("err_clr_cf.err", 32'(bus.err), 32'h1);

        // Five consecutive conflict edges, then err_clr
        drive(2'b00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
        tick("cnt_zero");
        drive(2'b10, 8'h00, 1'b1, 8'h10, 8'h10, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick("cnt_run");
            chk("cnt_run.err", 32'(bus.err), 32'h1);
`ifdef DFF_BANK_CONFLICT_CNT_EN
            chk("cnt_run.cnt", 32'(bus.conflict_cnt), 32'(exp_cnt[i]));
`endif
        end
        drive(2'b00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
        tick("cnt_clr");
        chk("cnt_clr.err", 32'(bus.err), 32'h0);
`ifdef DFF_BANK_CONFLICT_CNT_EN
        chk("cnt_clr.cnt", 32'(bus.conflict_cnt), 32'h0);
`endif

        // Randomized traffic with sparse conflicts, err_clr and async resets
        for (int i = 0; i < 300; i++) begin
            logic [7:0] s;
            logic [7:0] c;
            s = 8'($urandom) & 8'($urandom);
            c = 8'($urandom) & 8'($urandom) & ~(($urandom_range(0, 3) == 0) ? 8'h00 : s);
            drive(2'($urandom), 8'($urandom), 1'($urandom), s, c,
                  ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 24) == 0) begin
                #2;
                clear = 1'b1;
                #1;
                model_reset();
                check_state("rnd_async");
                tick("rnd_in_reset");
                clear = 1'b0;
            end else begin
                tick("rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
